// File: rtl/fsqrt_pkg.sv
// Shared types and constants for the single-precision square-root controller.
// Optional build macro: FSQRT_DAZ_EN (denormal operands are treated as signed zero).
package fsqrt_pkg;

  localparam int unsigned ROOT_W = 32;         // core radicand/root width
  localparam int unsigned EXP_W  = 8;          // exponent width
  localparam int unsigned MAN_W  = 23;         // stored mantissa width
  localparam int unsigned SUM_W  = MAN_W + 1;  // mantissa plus rounding carry
  localparam int unsigned LZ_W   = 5;          // leading-zero count width
  localparam int unsigned EE_W   = 10;         // signed effective-exponent width
  localparam int unsigned BIAS   = 127;

  localparam logic [31:0] QNAN = 32'h7FC0_0000;
  localparam logic [31:0] PINF = 32'h7F80_0000;

  localparam logic [1:0] RM_RNE = 2'b00;
  localparam logic [1:0] RM_RZ  = 2'b01;
  localparam logic [1:0] RM_RU  = 2'b10;
  localparam logic [1:0] RM_RD  = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_UNPK,
    ST_LAUNCH,
    ST_WAIT,
    ST_ROUND,
    ST_DONE,
    ST_SPEC
  } state_e;

  // Operand bypasses the root core (NaN, inf, zero, any negative value).
  function automatic logic is_special(input logic [31:0] x);
    logic exp_max;
    logic exp_zero;
    exp_max  = &x[30:23];
    exp_zero = ~|x[30:23];
`ifdef FSQRT_DAZ_EN
    return exp_max | exp_zero | x[31];
`else
    return exp_max | (exp_zero & ~|x[22:0]) | x[31];
`endif
  endfunction

endpackage

// File: rtl/fsqrt_lzc24.sv
// 24-bit leading-zero counter used to normalise denormal mantissas.
// Ports: val_i  - 24-bit value {hidden, fraction}
//        lz_c_o - combinational count of leading zeros (24 when val_i is 0)
module fsqrt_lzc24
  import fsqrt_pkg::*;
(
  input  logic [MAN_W:0]  val_i,
  output logic [LZ_W-1:0] lz_c_o
);

  // Scan upward so the highest set bit is the last one to write the count.
  always_comb begin
    lz_c_o = LZ_W'(SUM_W);
    for (int i = 0; i < int'(SUM_W); i++) begin
      if (val_i[i]) lz_c_o = LZ_W'(int'(MAN_W) - i);
    end
  end

endmodule

// File: rtl/fsqrt_ctrl.sv
// IEEE-754 single-precision square-root controller sitting between ID/EX and an
// external 32-bit fraction root core. Resolves special operands locally, otherwise
// normalises the operand, launches the core and rounds/packs its root.
// Optional build macro: FSQRT_DAZ_EN (denormals become signed zero, no normaliser).
// Ports:
//   clock, resetn        - clock, asynchronous active-low reset
//   fsqrt, a, rm         - start request, operand, rounding mode
//   s, invalid, inexact  - result and flags, valid with ready, held until next accept
//   busy, ready          - operation in flight / 1-cycle completion pulse
//   core_d, core_start   - radicand and start pulse to the root core
//   core_q, core_ready   - root and completion pulse from the root core
module fsqrt_ctrl
  import fsqrt_pkg::*;
(
  input  logic              clock,
  input  logic              resetn,
  input  logic              fsqrt,
  input  logic [31:0]       a,
  input  logic [1:0]        rm,
  output logic [31:0]       s,
  output logic              invalid,
  output logic              inexact,
  output logic              busy,
  output logic              ready,
  output logic [ROOT_W-1:0] core_d,
  output logic              core_start,
  input  logic [ROOT_W-1:0] core_q,
  input  logic              core_ready
);

  state_e              state_q;
  logic [31:0]         a_q;
  logic [1:0]          rm_q;
  logic [31:0]         s_q;
  logic                invalid_q, inexact_q, busy_q, ready_q, core_start_q;
  logic [ROOT_W-1:0]   core_d_q;
  logic [ROOT_W-2:0]   q_q;
  logic [EXP_W-1:0]    er_q;

  logic                zero_c;
  logic [MAN_W-1:0]    frac_c;
  logic signed [EE_W-1:0] e_eff_c, e_unb_c, e_adj_c, e_half_c;
  logic                e_odd_c;
  logic [EXP_W-1:0]    er_c;
  logic [ROOT_W-1:0]   rad_c;
  logic [31:0]         spec_s_c;
  logic                spec_inv_c;
  logic [MAN_W-1:0]    m_c;
  logic                g_c, st_c, up_c;
  logic [SUM_W-1:0]    sum_c;
  logic                unused_c;

  // Operand unpack: effective exponent and normalised fraction.
`ifdef FSQRT_DAZ_EN
  assign zero_c   = ~|a_q[30:23];
  assign frac_c   = a_q[MAN_W-1:0];
  assign e_eff_c  = $signed(EE_W'(a_q[30:23]));
  assign unused_c = core_q[ROOT_W-1];
`else
  logic [LZ_W-1:0] lz_c;
  logic [MAN_W:0]  norm_c;

  fsqrt_lzc24 u_lzc (
    .val_i  ({1'b0, a_q[MAN_W-1:0]}),
    .lz_c_o (lz_c)
  );

  // Denormal: move the leading one into the hidden position; e_eff = 1 - lz.
  assign norm_c   = {1'b0, a_q[MAN_W-1:0]} << lz_c;
  assign zero_c   = (~|a_q[30:23]) & (~|a_q[MAN_W-1:0]);
  assign frac_c   = (~|a_q[30:23]) ? norm_c[MAN_W-1:0] : a_q[MAN_W-1:0];
  assign e_eff_c  = (~|a_q[30:23]) ? ($signed(EE_W'(1)) - $signed(EE_W'(lz_c)))
                                   : $signed(EE_W'(a_q[30:23]));
  assign unused_c = core_q[ROOT_W-1] ^ norm_c[MAN_W];
`endif

  // Odd exponent feeds .1f, even feeds .01f so the root always lands in [.1, 1).
  assign e_unb_c  = e_eff_c - $signed(EE_W'(BIAS));
  assign e_odd_c  = e_unb_c[0];
  assign e_adj_c  = e_unb_c + (e_odd_c ? $signed(EE_W'(1)) : $signed(EE_W'(2)));
  assign e_half_c = e_adj_c >>> 1;
  assign er_c     = EXP_W'(e_half_c + $signed(EE_W'(BIAS - 1)));
  assign rad_c    = e_odd_c ? {1'b1, frac_c, 8'b0} : {2'b01, frac_c, 7'b0};

  // Special-operand result.
  always_comb begin
    spec_s_c   = PINF;
    spec_inv_c = 1'b0;
    if ((&a_q[30:23]) && (|a_q[MAN_W-1:0])) begin
      spec_s_c   = QNAN;
      spec_inv_c = ~a_q[MAN_W-1];
    end else if (zero_c) begin
      spec_s_c = {a_q[31], 31'b0};
    end else if (a_q[31]) begin
      spec_s_c   = QNAN;
      spec_inv_c = 1'b1;
    end
  end

  // Root rounding: bit 31 of the root is the hidden one.
  assign m_c  = q_q[30:8];
  assign g_c  = q_q[7];
  assign st_c = |q_q[6:0];

  always_comb begin
    up_c = 1'b0;
    case (rm_q)
      RM_RNE:  up_c = g_c & (st_c | m_c[0]);
      RM_RU:   up_c = g_c | st_c;
      default: up_c = 1'b0;
    endcase
  end

  assign sum_c = {1'b0, m_c} + SUM_W'(up_c);

  // Control FSM with registered outputs.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q      <= ST_IDLE;
      a_q          <= '0;
      rm_q         <= RM_RNE;
      s_q          <= '0;
      invalid_q    <= 1'b0;
      inexact_q    <= 1'b0;
      busy_q       <= 1'b0;
      ready_q      <= 1'b0;
      core_start_q <= 1'b0;
      core_d_q     <= '0;
      q_q          <= '0;
      er_q         <= '0;
    end else begin
      ready_q      <= 1'b0;
      core_start_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (fsqrt) begin
            a_q     <= a;
            rm_q    <= rm;
            busy_q  <= 1'b1;
            state_q <= is_special(a) ? ST_SPEC : ST_UNPK;
          end
        end
        ST_SPEC: begin
          s_q       <= spec_s_c;
          invalid_q <= spec_inv_c;
          inexact_q <= 1'b0;
          ready_q   <= 1'b1;
          state_q   <= ST_DONE;
        end
        ST_UNPK: begin
          core_d_q     <= rad_c;
          er_q         <= er_c;
          core_start_q <= 1'b1;
          state_q      <= ST_LAUNCH;
        end
        ST_LAUNCH: state_q <= ST_WAIT;
        ST_WAIT: begin
          if (core_ready) begin
            q_q     <= core_q[ROOT_W-2:0];
            state_q <= ST_ROUND;
          end
        end
        ST_ROUND: begin
          // A mantissa carry clears the fraction and bumps the exponent.
          s_q       <= {1'b0, er_q + EXP_W'(sum_c[MAN_W]), sum_c[MAN_W-1:0]};
          invalid_q <= 1'b0;
          inexact_q <= g_c | st_c;
          ready_q   <= 1'b1;
          state_q   <= ST_DONE;
        end
        ST_DONE: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign s          = s_q;
  assign invalid    = invalid_q;
  assign inexact    = inexact_q;
  assign busy       = busy_q;
  assign ready      = ready_q;
  assign core_d     = core_d_q;
  assign core_start = core_start_q;

endmodule

// File: tb/tb_fsqrt_ctrl.sv
// Bench for fsqrt_ctrl: behavioural root core, float-level sqrt reference model,
// directed corner cases and a randomized sweep.
module tb_fsqrt_ctrl;

  logic        clock = 1'b0;
  logic        resetn;
  logic        fsqrt;
  logic [31:0] a;
  logic [1:0]  rm;
  logic [31:0] s;
  logic        invalid, inexact, busy, ready;
  logic [31:0] core_d;
  logic        core_start;
  logic [31:0] core_q = 32'h0;
  logic        core_ready = 1'b0;

  int n_chk = 0;
  int n_pass = 0;
  int n_starts = 0;
  int core_cnt = 0;
  int core_fix_lat = 0;
  int core_d_err = 0;
  logic [31:0] core_lat_d = 32'h0;

  fsqrt_ctrl dut (
    .clock      (clock),
    .resetn     (resetn),
    .fsqrt      (fsqrt),
    .a          (a),
    .rm         (rm),
    .s          (s),
    .invalid    (invalid),
    .inexact    (inexact),
    .busy       (busy),
    .ready      (ready),
    .core_d     (core_d),
    .core_start (core_start),
    .core_q     (core_q),
    .core_ready (core_ready)
  );

  always #5 clock = ~clock;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  function automatic logic [31:0] isqrt64(input logic [63:0] x);
    logic [63:0] r, t;
    r = 64'd0;
    for (int b = 31; b >= 0; b--) begin
      t = r | (64'd1 << b);
      if (t * t <= x) r = t;
    end
    return r[31:0];
  endfunction

  // Behavioural root core: floor(sqrt(d * 2^32)) after a random latency.
  always @(negedge clock) begin
    core_ready = 1'b0;
    if (core_cnt > 0) begin
      if (busy && core_d !== core_lat_d) core_d_err++;
      core_cnt--;
      if (core_cnt == 0) begin
        core_ready = 1'b1;
        core_q = isqrt64({core_lat_d, 32'h0});
      end
    end
    if (core_start) begin
      n_starts++;
      core_lat_d = core_d;
      core_cnt = (core_fix_lat > 0) ? core_fix_lat : int'($urandom_range(1, 5));
    end
  end

  // Reference: {s, invalid, inexact} from float semantics with exact remainder.
  function automatic logic [33:0] ref_sqrt(input logic [31:0] x, input logic [1:0] mode);
    logic [63:0] mnt, xx, rr, mant;
    int k, sh, ex;
    logic g, st, up, daz;
`ifdef FSQRT_DAZ_EN
    daz = 1'b1;
`else
    daz = 1'b0;
`endif
    if (x[30:23] == 8'hFF && x[22:0] != 23'd0) return {32'h7FC00000, ~x[22], 1'b0};
    if (x[30:23] == 8'h00 && (x[22:0] == 23'd0 || daz)) return {x[31], 31'd0, 2'b00};
    if (x[31]) return {32'h7FC00000, 2'b10};
    if (x[30:23] == 8'hFF) return {32'h7F800000, 2'b00};
    if (x[30:23] == 8'h00) begin
      mnt = 64'(x[22:0]);
      k = -149;
    end else begin
      mnt = 64'({1'b1, x[22:0]});
      k = int'(x[30:23]) - 150;
    end
    while (mnt < 64'h80_0000) begin
      mnt = mnt << 1;
      k--;
    end
    if (k % 2 != 0) begin
      mnt = mnt << 1;
      k--;
    end
    xx = mnt << 38;
    rr = 64'(isqrt64(xx));
    sh = rr[31] ? 8 : 7;
    mant = rr >> sh;
    g = rr[sh-1];
    st = ((rr & ((64'd1 << (sh - 1)) - 64'd1)) != 64'd0) || (rr * rr != xx);
    case (mode)
      2'b00:   up = g & (st | mant[0]);
      2'b10:   up = g | st;
      default: up = 1'b0;
    endcase
    mant = mant + 64'(up);
    if (mant[24]) begin
      mant = mant >> 1;
      sh++;
    end
    ex = sh + k / 2 - 19 + 150;
    return {1'b0, 8'(ex), mant[22:0], 1'b0, g | st};
  endfunction

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  // One operation; hold_req keeps fsqrt high (with a scrambled operand) while busy.
  task automatic do_op(input logic [31:0] av, input logic [1:0] rmv, input logic hold_req,
                       output logic [31:0] so, output logic invo, output logic inxo,
                       output int lat);
    @(negedge clock);
    a = av;
    rm = rmv;
    fsqrt = 1'b1;
    @(negedge clock);
    fsqrt = hold_req;
    a = $urandom();
    rm = 2'($urandom_range(0, 3));
    lat = 1;
    while (!ready && lat < 100) begin
      @(negedge clock);
      lat++;
    end
    fsqrt = 1'b0;
    check_eq("op_ready", 64'(ready), 64'd1);
    so = s;
    invo = invalid;
    inxo = inexact;
    @(negedge clock);
    check_eq("ready_pulse", 64'(ready), 64'd0);
    check_eq("idle_after", 64'(busy), 64'd0);
  endtask

  logic [31:0] so;
  logic        iv, ix;
  int          lat, st0, seen;
  logic [33:0] exp_r;
  logic [31:0] spec_list [10] = '{32'h7F800000, 32'hFF800000, 32'h80000000, 32'h00000000,
                                  32'h7FC00000, 32'h7F800001, 32'hFFC12345, 32'h80000001,
                                  32'hBF800000, 32'h80400000};

  initial begin
    resetn = 1'b0;
    fsqrt = 1'b0;
    a = 32'h0;
    rm = 2'b00;
    repeat (3) @(negedge clock);
    check_eq("rst_outs", {27'd0, s, invalid, inexact, busy, ready, core_start},
             64'd0);
    check_eq("rst_core_d", 64'(core_d), 64'd0);
    resetn = 1'b1;

    // 4.0 exact
    st0 = n_starts;
    do_op(32'h40800000, 2'b00, 1'b0, so, iv, ix, lat);
    check_eq("sqrt4_s", 64'(so), 64'h40000000);
    check_eq("sqrt4_flags", {62'd0, iv, ix}, 64'd0);
    check_eq("sqrt4_starts", 64'(n_starts - st0), 64'd1);

    // 2.0 in three rounding modes
    do_op(32'h40000000, 2'b00, 1'b0, so, iv, ix, lat);
    check_eq("sqrt2_rne_s", 64'(so), 64'h3FB504F3);
    check_eq("sqrt2_rne_flags", {62'd0, iv, ix}, 64'd1);
    do_op(32'h40000000, 2'b01, 1'b0, so, iv, ix, lat);
    check_eq("sqrt2_rz_s", 64'(so), 64'h3FB504F3);
    do_op(32'h40000000, 2'b10, 1'b0, so, iv, ix, lat);
    check_eq("sqrt2_ru_s", 64'(so), 64'h3FB504F4);

    // -1.0: invalid, core untouched, fixed short latency
    st0 = n_starts;
    do_op(32'hBF800000, 2'b00, 1'b0, so, iv, ix, lat);
    check_eq("neg_s", 64'(so), 64'h7FC00000);
    check_eq("neg_flags", {62'd0, iv, ix}, 64'd2);
    check_eq("neg_latency", 64'(lat), 64'd2);
    check_eq("neg_no_start", 64'(n_starts - st0), 64'd0);

    // smallest denormal
    do_op(32'h00000001, 2'b00, 1'b0, so, iv, ix, lat);
`ifdef FSQRT_DAZ_EN
    check_eq("denorm_s", 64'(so), 64'h00000000);
    check_eq("denorm_flags", {62'd0, iv, ix}, 64'd0);
`else
    check_eq("denorm_s", 64'(so), 64'h1A3504F3);
    check_eq("denorm_flags", {62'd0, iv, ix}, 64'd1);
`endif

    do_op(32'h7F800000, 2'b00, 1'b0, so, iv, ix, lat);
    check_eq("pinf_s", 64'(so), 64'h7F800000);
    do_op(32'h80000000, 2'b00, 1'b0, so, iv, ix, lat);
    check_eq("nzero_s", 64'(so), 64'h80000000);
    check_eq("nzero_flags", {62'd0, iv, ix}, 64'd0);
    do_op(32'h7F800001, 2'b00, 1'b0, so, iv, ix, lat);
    check_eq("snan_s", 64'(so), 64'h7FC00000);
    check_eq("snan_inv", 64'(iv), 64'd1);
    do_op(32'h7FC00001, 2'b00, 1'b0, so, iv, ix, lat);
    check_eq("qnan_inv", 64'(iv), 64'd0);

    // fsqrt kept high through WAIT with another operand: ignored, not queued
    core_fix_lat = 4;
    do_op(32'h40000000, 2'b00, 1'b1, so, iv, ix, lat);
    check_eq("busy_ignore_s", 64'(so), 64'h3FB504F3);
    core_fix_lat = 0;

    // reset while waiting on the core; the late core_ready must be ignored
    core_fix_lat = 8;
    @(negedge clock);
    a = 32'h40000000;
    rm = 2'b00;
    fsqrt = 1'b1;
    @(negedge clock);
    fsqrt = 1'b0;
    repeat (2) @(negedge clock);
    check_eq("rst_pre_busy", 64'(busy), 64'd1);
    resetn = 1'b0;
    @(negedge clock);
    check_eq("rst_busy", 64'(busy), 64'd0);
    check_eq("rst_mid_core_d", 64'(core_d), 64'd0);
    resetn = 1'b1;
    seen = 0;
    repeat (12) begin
      @(negedge clock);
      if (ready) seen++;
    end
    check_eq("rst_no_ready", 64'(seen), 64'd0);
    check_eq("rst_idle", 64'(busy), 64'd0);
    core_fix_lat = 0;

    // randomized sweep against the reference model
    for (int n = 0; n < 300; n++) begin
      logic [31:0] av, diff;
      logic [1:0]  rmv;
      int          cat;
      cat = int'($urandom_range(0, 9));
      rmv = 2'($urandom_range(0, 3));
      if (cat == 0) av = spec_list[$urandom_range(0, 9)];
      else if (cat <= 2) av = {9'd0, 23'($urandom_range(1, 32'h7FFFFF))};
      else av = {1'b0, 8'($urandom_range(1, 254)), 23'($urandom())};
      exp_r = ref_sqrt(av, rmv);
      do_op(av, rmv, 1'b0, so, iv, ix, lat);
      check_eq("rnd_invalid", 64'(iv), 64'(exp_r[1]));
      if (cat == 0 || rmv[0]) begin
        check_eq("rnd_exact_s", 64'(so), 64'(exp_r[33:2]));
      end else begin
        diff = (so > exp_r[33:2]) ? so - exp_r[33:2] : exp_r[33:2] - so;
        check_eq("rnd_ulp_s", 64'(diff <= 32'd1), 64'd1);
      end
    end

    check_eq("core_d_stable", 64'(core_d_err), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
